// File: rtl/alu_mc_pkg.sv
// Shared opcode constants, FSM state encoding and flag bit positions for alu_multicycle.
package alu_mc_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;
    localparam logic [2:0] ALU_ADC = 3'b101;
    localparam logic [2:0] ALU_MUL = 3'b110;
    localparam logic [2:0] ALU_DIV = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_multicycle_if.sv
// Start/Busy/Done operand and result bundle between the control unit and alu_multicycle.
interface alu_multicycle_if #(parameter int WIDTH = 32);
    logic             Start;
    logic [2:0]       ALUControl;
    logic [WIDTH-1:0] Src_A;
    logic [WIDTH-1:0] Src_B;
    logic             Carry_In;
    logic [WIDTH-1:0] ALUResult;
    logic [WIDTH-1:0] ALUResult_Hi;
    logic [3:0]       ALUFlags;
    logic             Busy;
    logic             Done;

    modport master (
        output Start, ALUControl, Src_A, Src_B, Carry_In,
        input  ALUResult, ALUResult_Hi, ALUFlags, Busy, Done
    );

    modport slave (
        input  Start, ALUControl, Src_A, Src_B, Carry_In,
        output ALUResult, ALUResult_Hi, ALUFlags, Busy, Done
    );
endinterface

// File: rtl/mul_div_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider sharing one 2*WIDTH register.
// Divide step exists only when ALU_MC_DIV_EN is defined.
module mul_div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             start_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o,
    output logic             dbz_o
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q;
    logic               div_q;
    logic               run_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    // Multiplier: {hi, lo} starts as {0, A}; add B into hi when the lsb is set, then shift right.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

`ifdef ALU_MC_DIV_EN
    logic [WIDTH:0]     partial;
    logic [WIDTH:0]     diff;
    logic               geq;
    logic [2*WIDTH-1:0] div_next;

    // Divider: {rem, quo} starts as {0, A}; shift left and keep the trial subtraction if it fits.
    assign partial  = acc_q[2*WIDTH-1:WIDTH-1];
    assign diff     = partial - {1'b0, b_q};
    assign geq      = (partial >= {1'b0, b_q});
    assign div_next = geq ? {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                          : {partial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    assign acc_d    = div_q ? div_next : mul_next;
`else
    assign acc_d    = mul_next;
`endif

    assign done_o = run_q && (cnt_q == CNT_W'(WIDTH - 1));
    assign lo_o   = acc_d[WIDTH-1:0];
    assign hi_o   = acc_d[2*WIDTH-1:WIDTH];
    assign dbz_o  = div_q && (b_q == '0);

    always_ff @(posedge clk) begin
        if (srst) begin
            acc_q <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
            run_q <= 1'b0;
            cnt_q <= '0;
        end else if (start_i) begin
            acc_q <= {{WIDTH{1'b0}}, a_i};
            b_q   <= b_i;
            div_q <= is_div_i;
            run_q <= 1'b1;
            cnt_q <= '0;
        end else if (run_q) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (done_o) begin
                run_q <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle ADD/SUB/AND/ORR/EOR/ADC, iterative MUL and optional DIV.
// Define ALU_MC_DIV_EN to build the iterative divider for opcode 111.
module alu_multicycle
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic           CLK,
    input logic           RESET,
    alu_multicycle_if.slave bus
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d, hi_q, hi_d;
    logic [3:0]       flags_q, flags_d;

    logic             is_iter, iter_start, iter_done, iter_dbz;
    logic [WIDTH-1:0] iter_lo, iter_hi;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] sc_res;
    logic             sc_c, sc_v;

`ifdef ALU_MC_DIV_EN
    assign is_iter = (bus.ALUControl == ALU_MUL) || (bus.ALUControl == ALU_DIV);
`else
    assign is_iter = (bus.ALUControl == ALU_MUL);
`endif

    mul_div_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (CLK),
        .srst     (RESET),
        .start_i  (iter_start),
        .is_div_i (bus.ALUControl == ALU_DIV),
        .a_i      (bus.Src_A),
        .b_i      (bus.Src_B),
        .done_o   (iter_done),
        .lo_o     (iter_lo),
        .hi_o     (iter_hi),
        .dbz_o    (iter_dbz)
    );

    always_comb begin
        sum    = '0;
        sc_res = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        case (bus.ALUControl)
            ALU_ADD, ALU_ADC: begin
                sum    = {1'b0, bus.Src_A} + {1'b0, bus.Src_B}
                       + ((bus.ALUControl == ALU_ADC) ? {{WIDTH{1'b0}}, bus.Carry_In} : '0);
                sc_res = sum[WIDTH-1:0];
                sc_c   = sum[WIDTH];
                sc_v   = (bus.Src_A[WIDTH-1] == bus.Src_B[WIDTH-1])
                      && (sc_res[WIDTH-1] != bus.Src_A[WIDTH-1]);
            end
            ALU_SUB: begin
                sum    = {1'b0, bus.Src_A} + {1'b0, ~bus.Src_B} + (WIDTH+1)'(1);
                sc_res = sum[WIDTH-1:0];
                sc_c   = sum[WIDTH];
                sc_v   = (bus.Src_A[WIDTH-1] != bus.Src_B[WIDTH-1])
                      && (sc_res[WIDTH-1] != bus.Src_A[WIDTH-1]);
            end
            ALU_AND: sc_res = bus.Src_A & bus.Src_B;
            ALU_ORR: sc_res = bus.Src_A | bus.Src_B;
            ALU_EOR: sc_res = bus.Src_A ^ bus.Src_B;
            default: sc_res = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        res_d      = res_q;
        hi_d       = hi_q;
        flags_d    = flags_q;
        iter_start = 1'b0;
        case (state_q)
            S_CALC: begin
                if (iter_done) begin
                    state_d         = S_DONE;
                    res_d           = iter_lo;
                    hi_d            = iter_hi;
                    flags_d         = '0;
                    flags_d[FLAG_N] = iter_lo[WIDTH-1];
                    flags_d[FLAG_Z] = (iter_lo == '0);
                    flags_d[FLAG_V] = iter_dbz;
                end
            end
            default: begin
                // IDLE and DONE both accept a launch, giving zero-bubble back-to-back ops.
                state_d = S_IDLE;
                if (bus.Start) begin
                    if (is_iter) begin
                        state_d    = S_CALC;
                        iter_start = 1'b1;
                    end else begin
                        state_d         = S_DONE;
                        res_d           = sc_res;
                        hi_d            = '0;
                        flags_d[FLAG_N] = sc_res[WIDTH-1];
                        flags_d[FLAG_Z] = (sc_res == '0);
                        flags_d[FLAG_C] = sc_c;
                        flags_d[FLAG_V] = sc_v;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            res_q   <= '0;
            hi_q    <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            hi_q    <= hi_d;
            flags_q <= flags_d;
        end
    end

    assign bus.ALUResult    = res_q;
    assign bus.ALUResult_Hi = hi_q;
    assign bus.ALUFlags     = flags_q;
    assign bus.Busy         = (state_q == S_CALC);
    assign bus.Done         = (state_q == S_DONE);
endmodule
